// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC, selects the next fetch address among
// sequential / branch / jump / jump-register targets, runs the
// request/ready handshake with instruction memory and registers the
// fetched word for decode. Redirects that arrive while no fetch can
// complete are parked in a pending register and applied on the next
// completion, so the in-flight (delay-slot) instruction is never lost.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle out of reset, no request issued
// FETCH | requesting imem_addr whenever decode is not stalling
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid
);

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pend_target;
  logic        pend_valid;

  logic        redir_now;
  logic [31:0] redir_target;
  logic [31:0] next_target;
  logic        complete;

  // Request is combinational so releasing stall re-issues it in the same cycle.
  assign imem_req  = (state == FETCH) && !stall;
  assign imem_addr = pc & 32'hFFFF_FFFC;
  assign complete  = imem_req && imem_ready;

  // Redirect target selection: jr > jump > branch, then pending, then sequential.
  always_comb begin
    redir_now    = jr || jump || branch_taken;
    redir_target = pc_next;
    if (jr) begin
      redir_target = jr_addr & 32'hFFFF_FFFC;
    end else if (jump) begin
      redir_target = {pc_next[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      redir_target = pc_next + {branch_offset[29:0], 2'b00};
    end
    next_target = pc_next;
    if (redir_now) begin
      next_target = redir_target;
    end else if (pend_valid) begin
      next_target = pend_target;
    end
  end

  // Fetch sequencer: state, PC, pending redirect and registered instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      pend_target <= 32'h0;
      pend_valid  <= 1'b0;
    end else begin
      case (state)
        BOOT:    state <= FETCH;
        FETCH:   state <= FETCH;
        default: state <= BOOT;
      endcase

      if (complete) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        pc          <= next_target;
        pend_valid  <= 1'b0;
      end else begin
        // Stall freezes instr_valid; otherwise the pulse ends here.
        if (!stall) begin
          instr_valid <= 1'b0;
        end
        // Park a redirect that could not be applied; newest wins.
        if (redir_now) begin
          pend_target <= redir_target;
          pend_valid  <= 1'b1;
        end
      end
    end
  end

  // pend_target bits [1:0] are always 00 for jr/jump; branch targets inherit
  // the alignment of pc_next, so no extra masking is needed here.

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, wait states, redirect
// priority, pending redirect (with overwrite), stall, wrap-around and
// asynchronous reset. Memory returns word == address; pc_next = pc + 4.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;

  int passed = 0;
  int total  = 0;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_next      (pc_next),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid)
  );

  // addr_inst model and a memory whose word equals its address.
  assign pc_next    = pc + 32'd4;
  assign imem_rdata = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr_redir();
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
    jump          = 1'b0;
    jump_index    = 26'h0;
    jr            = 1'b0;
    jr_addr       = 32'h0;
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    imem_ready = 1'b1;
    clr_redir();

    // Reset state
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);

    @(negedge clk); rst = 1'b0;
    chk("boot_req", {31'b0, imem_req}, 32'h0);

    // Sequential fetch
    @(negedge clk);
    chk("seq_req", {31'b0, imem_req}, 32'h1);
    chk("seq_addr0", imem_addr, 32'h0);
    @(negedge clk);
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_instr0", instr, 32'h0);
    chk("seq_valid0", {31'b0, instr_valid}, 32'h1);
    @(negedge clk);
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_instr4", instr, 32'h4);
    @(negedge clk);
    chk("seq_addrC", imem_addr, 32'hC);
    chk("seq_instr8", instr, 32'h8);
    chk("seq_valid8", {31'b0, instr_valid}, 32'h1);

    // Wait states at pc=C
    imem_ready = 1'b0;
    @(negedge clk);
    chk("wait1_addr", imem_addr, 32'hC);
    chk("wait1_valid", {31'b0, instr_valid}, 32'h0);
    chk("wait1_instr", instr, 32'h8);
    @(negedge clk);
    chk("wait2_addr", imem_addr, 32'hC);
    chk("wait2_valid", {31'b0, instr_valid}, 32'h0);
    imem_ready = 1'b1;
    @(negedge clk);
    chk("wait_done_pc", pc, 32'h10);
    chk("wait_done_instr", instr, 32'hC);
    chk("wait_done_valid", {31'b0, instr_valid}, 32'h1);

    // Priority: jr beats jump beats branch (pc_next = 0x14)
    branch_taken  = 1'b1; branch_offset = 32'd3;
    jump          = 1'b1; jump_index    = 26'h40;
    jr            = 1'b1; jr_addr       = 32'h1003;
    @(negedge clk); clr_redir();
    chk("prio_addr", imem_addr, 32'h1000);
    chk("prio_slot", instr, 32'h10);

    // Branch alone, positive then negative offset
    branch_taken = 1'b1; branch_offset = 32'd3;
    @(negedge clk); clr_redir();
    chk("br_pos_addr", imem_addr, 32'h1010);
    branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFC;
    @(negedge clk); clr_redir();
    chk("br_neg_addr", imem_addr, 32'h1004);

    // Jump alone, with branch also asserted (jump wins)
    jump = 1'b1; jump_index = 26'h40;
    branch_taken = 1'b1; branch_offset = 32'd7;
    @(negedge clk); clr_redir();
    chk("jmp_addr", imem_addr, 32'h100);
    chk("jmp_slot", instr, 32'h1004);

    // Redirect during wait, newer overwrites older
    imem_ready = 1'b0;
    jump = 1'b1; jump_index = 26'h80;
    @(negedge clk); clr_redir();
    chk("pend1_addr", imem_addr, 32'h100);
    chk("pend1_valid", {31'b0, instr_valid}, 32'h0);
    jr = 1'b1; jr_addr = 32'h303;
    @(negedge clk); clr_redir();
    chk("pend2_addr", imem_addr, 32'h100);
    imem_ready = 1'b1;
    @(negedge clk);
    chk("pend_slot", instr, 32'h100);
    chk("pend_slot_valid", {31'b0, instr_valid}, 32'h1);
    chk("pend_addr", imem_addr, 32'h300);
    @(negedge clk);
    chk("pend_clear_addr", imem_addr, 32'h304);

    // Stall for 3 cycles; branch captured while stalled
    stall = 1'b1;
    #1;
    chk("stall_req", {31'b0, imem_req}, 32'h0);
    branch_taken = 1'b1; branch_offset = 32'd1;
    @(negedge clk); clr_redir();
    chk("stall1_pc", pc, 32'h304);
    chk("stall1_instr", instr, 32'h300);
    chk("stall1_valid", {31'b0, instr_valid}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("stall3_pc", pc, 32'h304);
    chk("stall3_valid", {31'b0, instr_valid}, 32'h1);
    chk("stall3_req", {31'b0, imem_req}, 32'h0);
    stall = 1'b0;
    #1;
    chk("unstall_req", {31'b0, imem_req}, 32'h1);
    chk("unstall_addr", imem_addr, 32'h304);
    @(negedge clk);
    chk("unstall_instr", instr, 32'h304);
    chk("stall_pend_addr", imem_addr, 32'h30C);

    // Wrap-around
    jr = 1'b1; jr_addr = 32'hFFFF_FFFE;
    @(negedge clk); clr_redir();
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_instr", instr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("pre_rst_pc", pc, 32'h4);

    // Asynchronous reset mid-cycle while waiting
    imem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer of the MIPS core. Holds the architectural PC and drives it to `addr_inst` (`in_pc`), then takes back `addr_inst`'s `pc_next` (PC+4). It selects the next fetch address among sequential, branch, jump and jump-register targets, runs the request/ready handshake with instruction memory, and presents the fetched word to decode. Stall and delayed-redirect handling live here, so downstream stages never see a half-completed fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word-aligned)
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc`  out  32  current PC, to `addr_inst.in_pc`
- `pc_next`  in  32  PC+4 from `addr_inst`
- `stall`  in  1  decode back-pressure; freezes the fetch
- `branch_taken`  in  1  conditional branch resolved taken
- `branch_offset`  in  32  sign-extended word offset
- `jump`  in  1  J/JAL
- `jump_index`  in  26  instruction index
- `jr`  in  1  JR/JALR
- `jr_addr`  in  32  register target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, bits [1:0] always 00
- `imem_ready`  in  1  memory completes the request this cycle; `imem_rdata` is valid in the same cycle
- `imem_rdata`  in  32  fetched instruction word
- `instr`  out  32  registered instruction to decode
- `instr_valid`  out  1  `instr` is new this cycle

## Operation
- **States:** BOOT, FETCH.
  - Reset enters BOOT.
  - BOOT goes to FETCH unconditionally on the next edge.
  - FETCH stays in FETCH.
- **Reset values:** `pc`=RESET_PC, `instr`=0, `instr_valid`=0, pending redirect cleared, state=BOOT.
- **Request:**
  - `imem_req` = (state==FETCH) & ~`stall` (combinational).
  - `imem_addr` = {`pc`[31:2], 2'b00}.
- **Completion:** a fetch completes on an edge where `imem_req`=1 and `imem_ready`=1. On that edge:
  - `instr` <= `imem_rdata`.
  - `instr_valid` <= 1.
  - `pc` <= the selected next target.
- **No completion, no stall:** `instr_valid` <= 0, `pc` holds, `instr` holds.
- **Stall=1:**
  - `pc`, `instr` and `instr_valid` hold their values.
  - No request is issued.
  - Redirect inputs are still captured into the pending register.
- **Target computation** (mod 2^32):
  - Branch = `pc_next` + (`branch_offset` << 2).
  - Jump = {`pc_next`[31:28], `jump_index`, 2'b00}.
  - JR = {`jr_addr`[31:2], 2'b00}.
- **Priority among simultaneous inputs:** `jr` > `jump` > `branch_taken` > pending redirect > sequential (`pc_next`).
- **Pending redirect:** a redirect asserted on an edge without completion is latched as `pend_target`/`pend_valid`. A newer redirect overwrites it. The next completion uses it and clears `pend_valid`.
- **Delay slot:** the instruction completing on the same edge a redirect is applied (the delay slot) is delivered normally. It is never squashed.
- **Wrap-around:** `pc`=32'hFFFF_FFFC with `pc_next`=0 fetches 0 next. No error is flagged.
- **Reset mid-fetch:** state and outputs return to their reset values immediately (asynchronous), and any outstanding request is dropped. Memory must tolerate an abandoned request.

## Timing
- After `rst` falls: edge 1 BOOT→FETCH; `imem_req`=1 during cycle 2, address RESET_PC.
- Fetch latency: `instr`/`instr_valid` update on the completion edge, visible the following cycle.
- Throughput: one instruction per cycle with `imem_ready` tied high and `stall`=0.
- Redirect latency: a redirect sampled on a completion edge steers the very next request.
- `stall` deassertion: the request reappears in the same cycle, combinationally.
- `instr_valid` is a one-cycle pulse per completion, except while held under `stall`.

## Test plan
- **Sequential fetch:** reset, RESET_PC=0, `imem_ready`=1, memory word = address → `imem_addr` 0,4,8,C on consecutive cycles; `instr`=0,4,8 each with `instr_valid`=1.
- **Wait states:** `imem_ready` low 2 cycles at pc=8 → `imem_addr` holds 8; `instr_valid`=0 for 2 cycles; `pc`=C after completion.
- **Branch/jump/jr priority:** at `pc_next`=32'h14, assert `branch_taken` with offset 3, `jump` with index 26'h40, and `jr` with 32'h1003 in one completion cycle → next `imem_addr`=32'h1000. Branch alone → 32'h20. Jump alone → 32'h100.
- **Redirect during wait:** `jump` to 32'h100 pulsed while `imem_ready`=0 → in-flight instruction (delay slot) delivered, then `imem_addr`=32'h100.
- **Stall:** `stall`=1 for 3 cycles → `imem_req`=0, `pc`/`instr`/`instr_valid` frozen. Release → fetch resumes at the same `pc`.
- **Wrap and async reset:** `pc`=32'hFFFF_FFFC fetches, then `imem_addr`=0. Assert `rst` mid-cycle while waiting → `pc`=RESET_PC and `instr_valid`=0 before the next edge.
